// File: rtl/mem_interface.sv
// rtl/mem_interface.sv - FWFT FIFO to frame-buffer RAM writer with 1-cycle registered read port
//
// Purpose:
//   Pops pixels from a first-word-fall-through FIFO and stores them at consecutive
//   addresses of an internal simple dual-port RAM. The write address wraps once
//   per frame. A random-access read port returns the stored pixels one cycle later.
//
// Optional feature macro: FRAME_DONE_EN
//   Defined:   adds o_frame_done, a 1-cycle pulse after the write to the last address.
//   Undefined: the port and its logic are absent.
//
// Ports:
//   i_clk          single clock for the FIFO side and the read port
//   i_rstn         asynchronous active-low reset (RAM contents are kept)
//   i_flush        restarts the frame: write address returns to 0
//   o_rd           FIFO pop strobe, registered; also the RAM write enable
//   i_rdata        FIFO head word (FWFT), written to RAM when o_rd is high
//   i_almostempty  FIFO almost-empty; high blocks the next pop
//   i_raddr        read address
//   o_rdata        registered read data, read-first against a same-cycle write
//   o_frame_done   frame-complete pulse (FRAME_DONE_EN only)

module mem_interface #(
    parameter int  DATA_WIDTH = 16,
    parameter int  BRAM_DEPTH = 230400,
    localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_flush,
    output logic                  o_rd,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_almostempty,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
`ifdef FRAME_DONE_EN
    ,
    output logic                  o_frame_done
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BRAM_DEPTH - 1);

    logic                  rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mem_wr;

    logic [DATA_WIDTH-1:0] mem [BRAM_DEPTH];

    // The pop strobe doubles as the write enable: the FWFT head word is valid in
    // the same cycle it is popped, so every pop stores exactly one word.
    assign mem_wr = rd_q;

    always_comb begin
        rd_d    = !i_almostempty && !i_flush;
        waddr_d = waddr_q;
        if (i_flush) begin
            waddr_d = '0;
        end else if (mem_wr) begin
            waddr_d = (waddr_q == LAST_ADDR) ? '0 : waddr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            rd_q    <= rd_d;
            waddr_q <= waddr_d;
        end
    end

    // RAM array kept free of reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_wr) begin
            mem[waddr_q] <= i_rdata;
        end
    end

    // Non-blocking read of the array gives read-first behaviour on an address collision.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rd    = rd_q;
    assign o_rdata = rdata_q;

`ifdef FRAME_DONE_EN
    logic done_q, done_d;

    always_comb begin
        done_d = mem_wr && (waddr_q == LAST_ADDR);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign o_frame_done = done_q;
`endif

endmodule

// File: tb/tb_mem_interface.sv
// tb/tb_mem_interface.sv - self-checking bench for mem_interface with a frame-buffer reference model

module tb_mem_interface;

    localparam int DW    = 16;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          flush = 1'b0;
    logic          ae    = 1'b1;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] raddr = '0;
    wire           o_rd;
    wire  [DW-1:0] o_rdata;
`ifdef FRAME_DONE_EN
    wire           o_frame_done;
`endif

    mem_interface #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_flush       (flush),
        .o_rd          (o_rd),
        .i_rdata       (wdata),
        .i_almostempty (ae),
        .i_raddr       (raddr),
        .o_rdata       (o_rdata)
`ifdef FRAME_DONE_EN
        ,
        .o_frame_done  (o_frame_done)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: frame buffer as an array, a write pointer that walks
    // 0..DEPTH-1 and wraps, and a pop that follows almost-empty by one cycle.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_val [DEPTH];
    int            m_wa = 0;
    bit            m_rd = 0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_rdata_ok = 1;
    bit            m_done = 0;
    int            m_done_cnt = 0;
    int            m_writes = 0;

    task automatic model_edge();
        logic [DW-1:0] nr;
        bit            nok;
        bit            nd;
        nok = m_val[raddr];
        nr  = m_mem[raddr];
        nd  = m_rd && (m_wa == DEPTH - 1);
        if (m_rd) begin
            m_mem[m_wa] = wdata;
            m_val[m_wa] = 1;
            m_writes++;
        end
        if (flush)     m_wa = 0;
        else if (m_rd) m_wa = (m_wa + 1) % DEPTH;
        m_rd       = !ae && !flush;
        m_rdata    = nr;
        m_rdata_ok = nok;
        m_done     = nd;
        if (nd) m_done_cnt++;
    endtask

    task automatic model_reset();
        m_wa = 0; m_rd = 0; m_rdata = '0; m_rdata_ok = 1; m_done = 0;
    endtask

    task automatic check_outputs();
        chk("o_rd", o_rd, m_rd);
        if (m_rdata_ok) chk("o_rdata", o_rdata, m_rdata);
`ifdef FRAME_DONE_EN
        chk("o_frame_done", o_frame_done, m_done);
`endif
    endtask

    // Inputs change on the falling edge; the model advances on the rising edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    typedef struct {
        bit ae;
        bit flush;
        bit exp_rd;
    } vec_t;

    vec_t tv[14];
    int   guard;
    int   dut_done_cnt = 0;

`ifdef FRAME_DONE_EN
    always @(posedge clk) if (rstn && o_frame_done) dut_done_cnt++;
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_val[i] = 0;
            m_mem[i] = '0;
        end

        // 1: reset held 100 ns with FIFO almost empty
        #100;
        chk("reset_rd", o_rd, 1'b0);
        chk("reset_rdata", o_rdata, 16'h0);
        @(negedge clk);
        rstn = 1'b1;

        // 2: table-driven pop strobe sequence, including a flush
        for (int i = 0; i < 10; i++) tv[i] = '{ae: 0, flush: 0, exp_rd: 1};
        tv[10] = '{ae: 1, flush: 0, exp_rd: 0};
        tv[11] = '{ae: 0, flush: 1, exp_rd: 0};
        tv[12] = '{ae: 0, flush: 0, exp_rd: 1};
        tv[13] = '{ae: 1, flush: 0, exp_rd: 0};
        for (int i = 0; i < 14; i++) begin
            ae    = tv[i].ae;
            flush = tv[i].flush;
            wdata = DW'($urandom);
            step();
            chk("tbl_rd", o_rd, tv[i].exp_rd);
        end
        flush = 1'b0;
        ae    = 1'b1;
        for (int a = 0; a < 12; a++) begin
            raddr = AW'(a);
            step();
        end

        // 3: random bursts across several frame wraps
        for (int c = 0; c < 700; c++) begin
            ae    = ($urandom_range(0, 3) == 0);
            wdata = DW'($urandom);
            raddr = AW'($urandom_range(0, DEPTH - 1));
            step();
        end
        chk("wraps_seen", (m_done_cnt >= 3), 1'b1);
`ifdef FRAME_DONE_EN
        chk("frame_done_count", dut_done_cnt, m_done_cnt);
`endif

        // 4: full readback
        ae = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            raddr = AW'(a);
            step();
        end

        // 5: flush mid-frame at write address 20
        ae = 1'b0;
        guard = 0;
        while ((m_wa != 20 || !m_rd) && guard < 300) begin
            wdata = DW'($urandom);
            step();
            guard++;
        end
        chk("flush_reach", (guard < 300), 1'b1);
        flush = 1'b1;
        wdata = 16'h5A5A;
        step();
        chk("flush_rd_low", o_rd, 1'b0);
        flush = 1'b0;
        step();
        chk("flush_rd_back", o_rd, 1'b1);
        wdata = 16'hA5A5;
        ae    = 1'b1;
        step();
        raddr = AW'(0);
        step();
        chk("flush_addr0", o_rdata, 16'hA5A5);
        raddr = AW'(20);
        step();
        chk("flush_addr20", o_rdata, 16'h5A5A);

        // 6: same-cycle read and write of address 7 returns the old word
        flush = 1'b1;
        step();
        flush = 1'b0;
        ae    = 1'b0;
        guard = 0;
        while (m_wa != 8 && guard < 50) begin
            wdata = (m_rd && m_wa == 7) ? 16'h1234 : DW'($urandom);
            step();
            guard++;
        end
        ae = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        ae    = 1'b0;
        raddr = AW'(7);
        guard = 0;
        while (guard < 50) begin
            if (m_rd && m_wa == 7) begin
                wdata = 16'hBEEF;
                step();
                chk("rf_old", o_rdata, 16'h1234);
                ae = 1'b1;
                step();
                chk("rf_new", o_rdata, 16'hBEEF);
                break;
            end
            wdata = DW'($urandom);
            step();
            guard++;
        end
        chk("rf_reach", (guard < 50), 1'b1);

        // Reset in the middle of a burst: address restarts, contents survive
        ae = 1'b0;
        for (int c = 0; c < 5; c++) begin
            wdata = DW'($urandom);
            step();
        end
        rstn = 1'b0;
        model_reset();
        #1;
        chk("midreset_rd", o_rd, 1'b0);
        chk("midreset_rdata", o_rdata, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            wdata = DW'($urandom);
            step();
        end
        ae = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            raddr = AW'(a);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
